// File: rtl/ysyx_25020047_wb_ctrl.sv
// rtl/ysyx_25020047_wb_ctrl.sv - fetch/execute/memory/writeback sequencing controller
module ysyx_25020047_wb_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ifu_req,
  input  logic        ifu_valid,
  input  logic [31:0] inst_type,
  input  logic [4:0]  rd,
  output logic        lsu_req,
  input  logic        lsu_valid,
  output logic        gpr_wen,
  output logic        pc_wen,
  output logic [31:0] retired,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [2:0]  state
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   retired_q, retired_d;
  logic [1:0]    err_code_q, err_code_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      retired_q  <= 32'd0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      retired_q  <= retired_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    retired_d  = retired_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        // A valid arriving on the last allowed cycle still wins over the timeout
        if (ifu_valid) begin
          state_d = S_EXEC;
        end else if (wait_q == WAIT_MAX) begin
          state_d    = S_ERR;
          err_code_d = 2'd2;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_EXEC: begin
        case (inst_type)
          32'h0000_0020, 32'h0000_0040: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          32'h0000_0001, 32'h0000_0002, 32'h0000_0008, 32'h0000_0010,
          32'h0000_0200, 32'h0000_0400, 32'h0000_0800: begin
            state_d = S_WB;
          end
          default: begin
            state_d    = S_ERR;
            err_code_d = 2'd1;
          end
        endcase
      end
      S_MEM: begin
        if (lsu_valid) begin
          state_d = S_WB;
        end else if (wait_q == WAIT_MAX) begin
          state_d    = S_ERR;
          err_code_d = 2'd3;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_WB: begin
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
        wait_d    = '0;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ifu_req  = (state_q == S_FETCH);
  assign lsu_req  = (state_q == S_MEM);
  assign pc_wen   = (state_q == S_WB);
  assign gpr_wen  = (state_q == S_WB) && (rd != 5'd0);
  assign err      = (state_q == S_ERR);
  assign err_code = err_code_q;
  assign retired  = retired_q;
  assign state    = state_q;

endmodule

// File: tb/tb_ysyx_25020047_wb_ctrl.sv
// tb/tb_ysyx_25020047_wb_ctrl.sv - directed self-checking bench for the writeback controller
module tb_ysyx_25020047_wb_ctrl;

  logic        clk;
  logic        rst_n, rst_n_t;
  logic        ifu_valid, ifu_valid_t;
  logic [31:0] inst_type;
  logic [4:0]  rd;
  logic        lsu_valid;

  logic        ifu_req, lsu_req, gpr_wen, pc_wen, err;
  logic [31:0] retired;
  logic [1:0]  err_code;
  logic [2:0]  state;

  logic        ifu_req_t, lsu_req_t, gpr_wen_t, pc_wen_t, err_t;
  logic [31:0] retired_t;
  logic [1:0]  err_code_t;
  logic [2:0]  state_t;

  int n_checks;
  int n_fail;

  ysyx_25020047_wb_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ifu_req(ifu_req), .ifu_valid(ifu_valid),
    .inst_type(inst_type), .rd(rd), .lsu_req(lsu_req), .lsu_valid(lsu_valid),
    .gpr_wen(gpr_wen), .pc_wen(pc_wen), .retired(retired), .err(err),
    .err_code(err_code), .state(state)
  );

  ysyx_25020047_wb_ctrl #(.TIMEOUT(3)) dut_t (
    .clk(clk), .rst_n(rst_n_t), .ifu_req(ifu_req_t), .ifu_valid(ifu_valid_t),
    .inst_type(inst_type), .rd(rd), .lsu_req(lsu_req_t), .lsu_valid(lsu_valid),
    .gpr_wen(gpr_wen_t), .pc_wen(pc_wen_t), .retired(retired_t), .err(err_t),
    .err_code(err_code_t), .state(state_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state); end
    n_checks++; if ({ifu_req, lsu_req, gpr_wen, pc_wen, err} !== 5'b0) begin n_fail++; $display("FAIL reset_outs: got %b exp 00000", {ifu_req, lsu_req, gpr_wen, pc_wen, err}); end
    n_checks++; if (retired !== 32'd0 || err_code !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got retired=%0h code=%0d exp 0/0", retired, err_code); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (state !== 3'd1 || ifu_req !== 1'b1) begin n_fail++; $display("FAIL reset_leave: got state=%0d ifu_req=%b exp 1/1", state, ifu_req); end
  endtask

  task automatic test_alu();
    logic [2:0] seq [3];
    seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd4;
    ifu_valid = 1'b1; inst_type = 32'h1; rd = 5'd5;
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (state !== seq[i % 3]) begin n_fail++; $display("FAIL alu_state[%0d]: got %0d exp %0d", i, state, seq[i % 3]); end
      n_checks++; if (gpr_wen !== (i % 3 == 2) || pc_wen !== (i % 3 == 2)) begin n_fail++; $display("FAIL alu_wen[%0d]: got gpr=%b pc=%b exp %b", i, gpr_wen, pc_wen, (i % 3 == 2)); end
      tick();
    end
    n_checks++; if (retired !== 32'd3) begin n_fail++; $display("FAIL alu_retired: got %0d exp 3", retired); end
  endtask

  task automatic test_load();
    inst_type = 32'h20; rd = 5'd0; lsu_valid = 1'b0; ifu_valid = 1'b1;
    n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL load_fetch: got %0d exp 1", state); end
    tick();
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL load_exec: got %0d exp 2", state); end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (state !== 3'd3 || lsu_req !== 1'b1 || ifu_req !== 1'b0 || pc_wen !== 1'b0) begin n_fail++; $display("FAIL load_mem[%0d]: got state=%0d lsu=%b ifu=%b pc=%b exp 3/1/0/0", i, state, lsu_req, ifu_req, pc_wen); end
      if (i == 4) lsu_valid = 1'b1;
      tick();
    end
    lsu_valid = 1'b0;
    n_checks++; if (state !== 3'd4 || gpr_wen !== 1'b0 || pc_wen !== 1'b1 || lsu_req !== 1'b0) begin n_fail++; $display("FAIL load_wb: got state=%0d gpr=%b pc=%b lsu=%b exp 4/0/1/0", state, gpr_wen, pc_wen, lsu_req); end
    tick();
    n_checks++; if (retired !== 32'd4 || state !== 3'd1) begin n_fail++; $display("FAIL load_retired: got %0d state=%0d exp 4/1", retired, state); end
  endtask

  task automatic test_illegal();
    inst_type = 32'h4; rd = 5'd7; ifu_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (state !== 3'd5 || err !== 1'b1 || err_code !== 2'd1) begin n_fail++; $display("FAIL illegal_err[%0d]: got state=%0d err=%b code=%0d exp 5/1/1", i, state, err, err_code); end
      n_checks++; if ({ifu_req, lsu_req, gpr_wen, pc_wen} !== 4'b0 || retired !== 32'd4) begin n_fail++; $display("FAIL illegal_hold[%0d]: got outs=%b retired=%0d exp 0000/4", i, {ifu_req, lsu_req, gpr_wen, pc_wen}, retired); end
      ifu_valid = ~ifu_valid; lsu_valid = ~lsu_valid; inst_type = 32'h1;
      tick();
    end
    lsu_valid = 1'b0;
  endtask

  task automatic test_timeout();
    ifu_valid_t = 1'b0; lsu_valid = 1'b0;
    rst_n_t = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (state_t !== 3'd1 || err_t !== 1'b0) begin n_fail++; $display("FAIL fetch_wait[%0d]: got state=%0d err=%b exp 1/0", i, state_t, err_t); end
      tick();
    end
    n_checks++; if (state_t !== 3'd5 || err_t !== 1'b1 || err_code_t !== 2'd2) begin n_fail++; $display("FAIL fetch_timeout: got state=%0d err=%b code=%0d exp 5/1/2", state_t, err_t, err_code_t); end
    rst_n_t = 1'b0;
    #1;
    n_checks++; if (state_t !== 3'd0 || err_t !== 1'b0 || err_code_t !== 2'd0) begin n_fail++; $display("FAIL timeout_reset: got state=%0d err=%b code=%0d exp 0/0/0", state_t, err_t, err_code_t); end
    tick();
    rst_n_t = 1'b1;
    inst_type = 32'h40;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ifu_valid_t = 1'b1;
      tick();
    end
    n_checks++; if (state_t !== 3'd2 || err_t !== 1'b0) begin n_fail++; $display("FAIL fetch_late_valid: got state=%0d err=%b exp 2/0", state_t, err_t); end
    ifu_valid_t = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (state_t !== 3'd3) begin n_fail++; $display("FAIL mem_wait[%0d]: got %0d exp 3", i, state_t); end
      tick();
    end
    n_checks++; if (state_t !== 3'd5 || err_code_t !== 2'd3 || lsu_req_t !== 1'b0) begin n_fail++; $display("FAIL mem_timeout: got state=%0d code=%0d lsu=%b exp 5/3/0", state_t, err_code_t, lsu_req_t); end
  endtask

  task automatic test_async_reset();
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (state !== 3'd0 || err !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL err_reset: got state=%0d err=%b code=%0d exp 0/0/0", state, err, err_code); end
    tick();
    rst_n = 1'b1;
    tick();
    inst_type = 32'h1; rd = 5'd1; ifu_valid = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    n_checks++; if (retired !== 32'd7 || state !== 3'd1) begin n_fail++; $display("FAIL pre_retired: got %0d state=%0d exp 7/1", retired, state); end
    inst_type = 32'h20;
    tick();
    tick();
    tick();
    n_checks++; if (state !== 3'd3 || lsu_req !== 1'b1) begin n_fail++; $display("FAIL pre_mem: got state=%0d lsu=%b exp 3/1", state, lsu_req); end
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (state !== 3'd0 || retired !== 32'd0 || {ifu_req, lsu_req, gpr_wen, pc_wen, err} !== 5'b0) begin n_fail++; $display("FAIL async_reset: got state=%0d retired=%0d outs=%b exp 0/0/00000", state, retired, {ifu_req, lsu_req, gpr_wen, pc_wen, err}); end
    tick();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_held: got %0d exp 0", state); end
    rst_n = 1'b1;
    inst_type = 32'h1; rd = 5'd0;
    tick();
    tick();
    tick();
    n_checks++; if (state !== 3'd4 || pc_wen !== 1'b1 || gpr_wen !== 1'b0) begin n_fail++; $display("FAIL resume_wb: got state=%0d pc=%b gpr=%b exp 4/1/0", state, pc_wen, gpr_wen); end
    tick();
    n_checks++; if (retired !== 32'd1) begin n_fail++; $display("FAIL resume_retired: got %0d exp 1", retired); end
  endtask

  task automatic test_wrap();
    ifu_valid = 1'b0;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    n_checks++; if (retired !== 32'hFFFF_FFFF || state !== 3'd1) begin n_fail++; $display("FAIL wrap_preload: got %0h state=%0d exp ffffffff/1", retired, state); end
    ifu_valid = 1'b1; inst_type = 32'h800; rd = 5'd3;
    tick();
    tick();
    n_checks++; if (state !== 3'd4 || gpr_wen !== 1'b1) begin n_fail++; $display("FAIL wrap_wb: got state=%0d gpr=%b exp 4/1", state, gpr_wen); end
    tick();
    n_checks++; if (retired !== 32'd0 || state !== 3'd1) begin n_fail++; $display("FAIL wrap_zero: got %0h state=%0d exp 0/1", retired, state); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] types [5];
    types[0] = 32'h2; types[1] = 32'h8; types[2] = 32'h10; types[3] = 32'h200; types[4] = 32'h400;
    ifu_valid = 1'b1; rd = 5'd9;
    for (int i = 0; i < 5; i++) begin
      inst_type = types[i];
      tick();
      n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL b2b_exec[%0d]: got %0d exp 2", i, state); end
      tick();
      n_checks++; if (state !== 3'd4 || pc_wen !== 1'b1 || gpr_wen !== 1'b1) begin n_fail++; $display("FAIL b2b_wb[%0d]: got state=%0d pc=%b gpr=%b exp 4/1/1", i, state, pc_wen, gpr_wen); end
      tick();
    end
    n_checks++; if (retired !== 32'd5 || err !== 1'b0) begin n_fail++; $display("FAIL b2b_retired: got %0d err=%b exp 5/0", retired, err); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; rst_n_t = 1'b0;
    ifu_valid = 1'b0; ifu_valid_t = 1'b0;
    inst_type = 32'h0; rd = 5'd0; lsu_valid = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_illegal();
    test_timeout();
    test_async_reset();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
